// File: rtl/psi_pkg.sv
// Shared definitions for the psi set loader: FSM states and width/offset helpers.
package psi_pkg;

    // LOAD collects beats; FULL presents the finished vector to psi.
    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } state_t;

    // Index width for a range of x values: max(1, clog2(x)).
    function automatic int idx_width(input int x);
        return ($clog2(x) > 1) ? $clog2(x) : 1;
    endfunction

    // Bit offset of party p's slice inside the packed n*b vector.
    function automatic int slice_offset(input int p, input int b);
        return p * b;
    endfunction

endpackage

// File: rtl/psi_set_loader.sv
// Collects (party, element) beats into per-party membership slices and hands
// the packed n*b vector to the psi stage once every party has closed its set.
module psi_set_loader
    import psi_pkg::*;
#(
    parameter int b = 10,
    parameter int n = 4,
    localparam int pw = idx_width(n),
    localparam int ew = idx_width(b)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [pw-1:0]   in_party,
    input  logic [ew-1:0]   in_elem,
    input  logic            in_nodata,
    input  logic            in_last,
    output logic [n*b-1:0]  all_input,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            err
);

    state_t           state;
    state_t           state_nxt;
    logic [n*b-1:0]   bits;
    logic [n*b-1:0]   bits_nxt;
    logic [n-1:0]     done;
    logic [n-1:0]     done_nxt;
    logic [n-1:0]     hit;
    logic             party_ok;
    logic             closed;
    logic             elem_ok;
    logic             accept;
    logic             err_set;

    // Handshake outputs come straight from the state register; in_ready is
    // also held low while reset is asserted.
    assign in_ready  = (state == LOAD) && !rst;
    assign out_valid = (state == FULL);
    assign all_input = bits;
    assign accept    = in_valid && in_ready;

    // One-hot decode of the beat's party and range checks on party/element.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch
        // can be inferred on any path.
        hit = '0;
        for (int p = 0; p < n; p++) begin
            hit[p] = (int'(in_party) == p);
        end
        party_ok = |hit;
        closed   = |(hit & done);
        elem_ok  = (int'(in_elem) < b);
    end

    // Next-state, next-vector and error decision for the current cycle.
    always_comb begin
        state_nxt = state;
        bits_nxt  = bits;
        done_nxt  = done;
        err_set   = 1'b0;
        case (state)
            LOAD: begin
                if (accept) begin
                    if (!party_ok || closed) begin
                        // Unknown party or already-closed set: drop the whole beat.
                        err_set = 1'b1;
                    end else begin
                        if (!in_nodata) begin
                            if (elem_ok) begin
                                for (int p = 0; p < n; p++) begin
                                    for (int e = 0; e < b; e++) begin
                                        if (hit[p] && (int'(in_elem) == e)) begin
                                            bits_nxt[slice_offset(p, b) + e] = 1'b1;
                                        end
                                    end
                                end
                            end else begin
                                // Out-of-universe element is dropped; in_last still counts.
                                err_set = 1'b1;
                            end
                        end
                        if (in_last) begin
                            done_nxt = done | hit;
                        end
                    end
                end
                // The closing beat of this cycle already counts toward completion.
                if (&done_nxt) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (out_ready) begin
                    state_nxt = LOAD;
                    bits_nxt  = '0;
                    done_nxt  = '0;
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Membership register file, done mask and sticky error flag.
    always_ff @(posedge clk) begin
        // NOTE: the membership vector is plain flops, not a RAM, so it is
        // cleared by reset; a reset mid-round must discard partial sets.
        if (rst) begin
            bits <= '0;
            done <= '0;
            err  <= 1'b0;
        end else begin
            bits <= bits_nxt;
            done <= done_nxt;
            err  <= err | err_set;
        end
    end

endmodule

// File: tb/tb_psi_set_loader.sv
// Directed, table-driven bench for psi_set_loader with b = 10, n = 4.
module tb_psi_set_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_party;
    logic [3:0]  in_elem;
    logic        in_nodata;
    logic        in_last;
    logic [39:0] all_input;
    logic        out_valid;
    logic        out_ready;
    logic        err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        valid;
        logic [1:0]  party;
        logic [3:0]  elem;
        logic        nodata;
        logic        last;
        logic        ordy;
        logic [39:0] exp_all;
        logic        exp_ovalid;
        logic        exp_iready;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    psi_set_loader #(.b(10), .n(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_party  (in_party),
        .in_elem   (in_elem),
        .in_nodata (in_nodata),
        .in_last   (in_last),
        .all_input (all_input),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] p, input logic [3:0] e,
                         input logic nd, input logic l, input logic ordy);
        in_valid  = v;
        in_party  = p;
        in_elem   = e;
        in_nodata = nd;
        in_last   = l;
        out_ready = ordy;
    endtask

    task automatic add(input logic v, input logic [1:0] p, input logic [3:0] e,
                       input logic nd, input logic l, input logic ordy,
                       input logic [39:0] xa, input logic xv, input logic xr, input logic xe);
        vec_t t;
        t.valid = v; t.party = p; t.elem = e; t.nodata = nd; t.last = l; t.ordy = ordy;
        t.exp_all = xa; t.exp_ovalid = xv; t.exp_iready = xr; t.exp_err = xe;
        tbl.push_back(t);
    endtask

    function automatic logic [39:0] pk(input logic [9:0] s3, input logic [9:0] s2,
                                       input logic [9:0] s1, input logic [9:0] s0);
        return {s3, s2, s1, s0};
    endfunction

    function automatic logic [9:0] and_slices(input logic [39:0] v);
        return v[9:0] & v[19:10] & v[29:20] & v[39:30];
    endfunction

    logic [39:0] held;

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;

        // Reset held for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rst_iready_%0d", i), in_ready, 0);
        end
        check("rst_all", all_input, 0);
        check("rst_ovalid", out_valid, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        #1;
        check("post_rst_iready", in_ready, 1);

        // Round 1: basic round, then handshake.
        add(1, 0, 1, 0, 0, 0, pk(10'h000, 10'h000, 10'h000, 10'h002), 0, 1, 0);
        add(1, 0, 3, 0, 1, 0, pk(10'h000, 10'h000, 10'h000, 10'h00A), 0, 1, 0);
        add(1, 1, 3, 0, 0, 0, pk(10'h000, 10'h000, 10'h008, 10'h00A), 0, 1, 0);
        add(1, 1, 5, 0, 1, 0, pk(10'h000, 10'h000, 10'h028, 10'h00A), 0, 1, 0);
        add(1, 2, 3, 0, 1, 0, pk(10'h000, 10'h008, 10'h028, 10'h00A), 0, 1, 0);
        add(1, 3, 3, 0, 0, 0, pk(10'h008, 10'h008, 10'h028, 10'h00A), 0, 1, 0);
        add(1, 3, 9, 0, 1, 0, pk(10'h208, 10'h008, 10'h028, 10'h00A), 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 40'h0, 0, 1, 0);
        // Round 2: empty set via nodata (elem ignored), duplicate element.
        add(1, 2, 7, 1, 1, 0, 40'h0, 0, 1, 0);
        add(1, 0, 4, 0, 0, 0, pk(10'h000, 10'h000, 10'h000, 10'h010), 0, 1, 0);
        add(1, 0, 4, 0, 1, 0, pk(10'h000, 10'h000, 10'h000, 10'h010), 0, 1, 0);
        add(1, 1, 0, 0, 1, 0, pk(10'h000, 10'h000, 10'h001, 10'h010), 0, 1, 0);
        add(1, 3, 9, 0, 1, 0, pk(10'h200, 10'h000, 10'h001, 10'h010), 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 40'h0, 0, 1, 0);
        // Round 3: out-of-range element closing p1, then a beat to closed p1.
        add(1, 1, 12, 0, 1, 0, 40'h0, 0, 1, 1);
        add(1, 1, 2, 0, 0, 0, 40'h0, 0, 1, 1);
        add(1, 0, 0, 0, 1, 0, pk(10'h000, 10'h000, 10'h000, 10'h001), 0, 1, 1);
        add(1, 2, 1, 0, 1, 0, pk(10'h000, 10'h002, 10'h000, 10'h001), 0, 1, 1);
        add(1, 3, 2, 0, 1, 0, pk(10'h004, 10'h002, 10'h000, 10'h001), 1, 0, 1);

        foreach (tbl[i]) begin
            drive(tbl[i].valid, tbl[i].party, tbl[i].elem, tbl[i].nodata, tbl[i].last, tbl[i].ordy);
            step();
            check($sformatf("v%0d_all", i), all_input, tbl[i].exp_all);
            check($sformatf("v%0d_ovalid", i), out_valid, tbl[i].exp_ovalid);
            check($sformatf("v%0d_iready", i), in_ready, tbl[i].exp_iready);
            check($sformatf("v%0d_err", i), err, tbl[i].exp_err);
            if (i == 6) check("psi_and_round1", and_slices(all_input), 10'h008);
        end

        // Backpressure: FULL with out_ready low and a pending beat.
        held = all_input;
        drive(1, 0, 5, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("bp_iready_%0d", i), in_ready, 0);
            check($sformatf("bp_ovalid_%0d", i), out_valid, 1);
            check($sformatf("bp_all_%0d", i), all_input, held);
        end
        drive(0, 0, 0, 0, 0, 1);
        step();
        check("bp_release_all", all_input, 0);
        check("bp_release_ovalid", out_valid, 0);
        check("bp_release_iready", in_ready, 1);
        check("bp_release_err", err, 1);
        drive(0, 0, 0, 0, 0, 0);
        step();
        check("bp_no_consume", all_input, 0);

        // Mid-round reset: close p0 and p1, reset, then a full fresh round.
        drive(1, 0, 7, 0, 1, 0);
        step();
        drive(1, 1, 8, 0, 1, 0);
        step();
        check("mr_pre_all", all_input, pk(10'h000, 10'h000, 10'h100, 10'h080));
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        check("mr_rst_all", all_input, 0);
        check("mr_rst_err", err, 0);
        check("mr_rst_iready", in_ready, 0);
        rst = 1'b0;
        #1;
        check("mr_post_iready", in_ready, 1);
        for (int p = 0; p < 3; p++) begin
            drive(1, 2'(p), 4'(p), 0, 1, 0);
            step();
        end
        check("mr_3of4_ovalid", out_valid, 0);
        drive(1, 3, 3, 0, 1, 0);
        step();
        check("mr_full_ovalid", out_valid, 1);
        check("mr_full_all", all_input, pk(10'h008, 10'h004, 10'h002, 10'h001));
        check("mr_full_err", err, 0);
        drive(0, 0, 0, 0, 0, 1);
        step();
        check("mr_done_ovalid", out_valid, 0);
        check("mr_done_all", all_input, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
